if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction fetch stage of a classic 5-stage MIPS-style pipeline
//
// Holds the program counter and the IF/ID pipeline register. The current PC
// goes straight to an instruction ROM. The ROM returns the instruction word in
// the same cycle. On each rising edge the fetched word is captured into IF/ID
// together with its PC+4, unless the stage is stalled, flushed or redirected.
//
// Parameters
//   RESET_PC       PC value loaded while Clrn is low
//
// Ports
//   Clk            rising-edge clock for all state
//   Clrn           asynchronous active-low reset
//   Stall          hold PC and IF/ID (a redirect still overrides the PC hold)
//   Flush          bubble IF/ID; the PC is not affected
//   Branch_Taken   redirect PC to Branch_Target (low two bits forced to zero)
//   Branch_Target  byte address of the branch destination
//   Jump           redirect PC to {IF_ID_PC4[31:28], Jump_Index, 2'b00}
//   Jump_Index     26-bit instr_index field of the J-type instruction
//   INST           instruction word returned by the ROM for Addr
//   Addr           current PC, to the instruction ROM
//   IF_ID_Inst     registered instruction for decode (0 = NOP bubble)
//   IF_ID_PC4      registered PC+4 of IF_ID_Inst
//   IF_ID_Valid    IF_ID_Inst holds a real fetched instruction
//   Fetch_Count    free-running count of instructions accepted into IF/ID
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [25:0] Jump_Index,
    input  logic [31:0] INST,
    output logic [31:0] Addr,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic [15:0] Fetch_Count
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;
    logic [15:0] r_fetch_count;

    // ------------------------------------------------------------------------
    // Combinational next-PC datapath
    // ------------------------------------------------------------------------
    logic [31:0] w_pc4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_redirect;
    logic [31:0] w_pc_next;

    // Natural 32-bit wrap: 32'hFFFFFFFC + 4 = 0.
    assign w_pc4 = r_pc + 32'd4;

    // The jump region comes from the PC+4 of the jump instruction. That
    // instruction sits in IF/ID when Jump is raised by decode.
    assign w_jump_target = {r_if_id_pc4[31:28], Jump_Index, 2'b00};

    // Instruction addresses are word aligned. Masking every bit rather than
    // slicing keeps all of Branch_Target consumed.
    assign w_branch_target = Branch_Target & 32'hFFFF_FFFC;

    assign w_redirect = Jump | Branch_Taken;

    // Jump > Branch_Taken > Stall (hold) > sequential. A redirect beats Stall
    // because the stalled instruction lies on the wrong path anyway.
    always_comb begin
        w_pc_next = w_pc4;
        if (Jump) begin
            w_pc_next = w_jump_target;
        end else if (Branch_Taken) begin
            w_pc_next = w_branch_target;
        end else if (Stall) begin
            w_pc_next = r_pc;
        end
    end

    // ------------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID register and fetch counter
    // A bubble is all-zero (sll $0,$0,0 is the MIPS NOP) with Valid low. Only
    // real loads bump Fetch_Count, which wraps rather than saturating.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_if_id_inst  <= 32'd0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 16'd0;
        end else if (w_redirect || Flush) begin
            r_if_id_inst  <= 32'd0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (!Stall) begin
            r_if_id_inst  <= INST;
            r_if_id_pc4   <= w_pc4;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Addr        = r_pc;
    assign IF_ID_Inst  = r_if_id_inst;
    assign IF_ID_PC4   = r_if_id_pc4;
    assign IF_ID_Valid = r_if_id_valid;
    assign Fetch_Count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage -- directed, table-driven bench for if_stage
//
// dut0 (RESET_PC = 0) runs a vector table. After each clock edge it checks
// Addr and all IF/ID outputs. Hand-written sequences then cover the
// asynchronous reset. dut1 (RESET_PC = 32'hFFFFFFFC) covers the PC wrap and
// the Fetch_Count wrap. Both instruction ROMs are the same bench function.
// ============================================================================
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instruction ROM model ----------------
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0000_0000;
            32'h0000_0004: rom = 32'h0041_1820;
            32'h0000_0008: rom = 32'hAC23_0000;
            32'h0000_000C: rom = 32'h8C64_0004;
            default:       rom = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // ---------------- dut0 ----------------
    logic        rst_n0, stall0, flush0, br0, jump0;
    logic [31:0] btgt0, inst0, addr0, ifid_inst0, ifid_pc40;
    logic [25:0] jidx0;
    logic        valid0;
    logic [15:0] cnt0;

    assign inst0 = rom(addr0);

    if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .Clk(clk), .Clrn(rst_n0), .Stall(stall0), .Flush(flush0),
        .Branch_Taken(br0), .Branch_Target(btgt0), .Jump(jump0),
        .Jump_Index(jidx0), .INST(inst0), .Addr(addr0),
        .IF_ID_Inst(ifid_inst0), .IF_ID_PC4(ifid_pc40),
        .IF_ID_Valid(valid0), .Fetch_Count(cnt0)
    );

    // ---------------- dut1 (wrap checks) ----------------
    logic        rst_n1;
    logic        stall1, flush1, br1, jump1;
    logic [31:0] btgt1, inst1, addr1, ifid_inst1, ifid_pc41;
    logic [25:0] jidx1;
    logic        valid1;
    logic [15:0] cnt1;

    assign inst1 = rom(addr1);

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .Clk(clk), .Clrn(rst_n1), .Stall(stall1), .Flush(flush1),
        .Branch_Taken(br1), .Branch_Target(btgt1), .Jump(jump1),
        .Jump_Index(jidx1), .INST(inst1), .Addr(addr1),
        .IF_ID_Inst(ifid_inst1), .IF_ID_PC4(ifid_pc41),
        .IF_ID_Valid(valid1), .Fetch_Count(cnt1)
    );

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all0(input string tag, input logic [31:0] e_addr,
                            input logic [31:0] e_inst, input logic [31:0] e_pc4,
                            input logic e_valid, input logic [15:0] e_cnt);
        chk({tag, ".addr"},  addr0,               e_addr);
        chk({tag, ".inst"},  ifid_inst0,          e_inst);
        chk({tag, ".pc4"},   ifid_pc40,           e_pc4);
        chk({tag, ".valid"}, {31'd0, valid0},     {31'd0, e_valid});
        chk({tag, ".count"}, {16'd0, cnt0},       {16'd0, e_cnt});
        $display("%s addr=%h inst=%h pc4=%h valid=%0d count=%0d",
                 tag, addr0, ifid_inst0, ifid_pc40, valid0, cnt0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] btgt;
        logic        jump;
        logic [25:0] jidx;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s, input logic f, input logic b,
                                input logic [31:0] bt, input logic j,
                                input logic [25:0] ji, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic ev, input logic [15:0] ec);
        vec_t v;
        v.stall = s; v.flush = f; v.br = b; v.btgt = bt; v.jump = j; v.jidx = ji;
        v.e_addr = ea; v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_cnt = ec;
        return v;
    endfunction

    // watchdog: the whole run is about 66k cycles
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //                st fl br target         jp index        addr           inst           pc4            v  cnt
        vecs[0]  = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1, 16'd1);
        vecs[1]  = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h0000_0008, 32'h0041_1820, 32'h0000_0008, 1, 16'd2);
        vecs[2]  = mk(1, 0, 0, 32'h0,          0, 26'h0,       32'h0000_0008, 32'h0041_1820, 32'h0000_0008, 1, 16'd2);
        vecs[3]  = mk(1, 0, 0, 32'h0,          0, 26'h0,       32'h0000_0008, 32'h0041_1820, 32'h0000_0008, 1, 16'd2);
        vecs[4]  = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h0000_000C, 32'hAC23_0000, 32'h0000_000C, 1, 16'd3);
        vecs[5]  = mk(0, 1, 0, 32'h0,          0, 26'h0,       32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 0, 16'd3);
        vecs[6]  = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h0000_0014, 32'hA5A5_0010, 32'h0000_0014, 1, 16'd4);
        vecs[7]  = mk(1, 0, 1, 32'h0000_0043,  0, 26'h0,       32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0, 16'd4);
        vecs[8]  = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h0000_0044, 32'hA5A5_0040, 32'h0000_0044, 1, 16'd5);
        vecs[9]  = mk(1, 1, 0, 32'h0,          0, 26'h0,       32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 0, 16'd5);
        vecs[10] = mk(0, 0, 1, 32'h4000_000C,  0, 26'h0,       32'h4000_000C, 32'h0000_0000, 32'h0000_0000, 0, 16'd5);
        vecs[11] = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h4000_0010, 32'hE5A5_000C, 32'h4000_0010, 1, 16'd6);
        vecs[12] = mk(0, 0, 1, 32'h0000_0100,  1, 26'h0000010, 32'h4000_0040, 32'h0000_0000, 32'h0000_0000, 0, 16'd6);
        vecs[13] = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h4000_0044, 32'hE5A5_0040, 32'h4000_0044, 1, 16'd7);
        vecs[14] = mk(1, 0, 0, 32'h0,          1, 26'h3FFFFFF, 32'h4FFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 16'd7);
        vecs[15] = mk(0, 0, 0, 32'h0,          0, 26'h0,       32'h5000_0000, 32'hEA5A_FFFC, 32'h5000_0000, 1, 16'd8);

        rst_n0 = 1'b0; stall0 = 0; flush0 = 0; br0 = 0; jump0 = 0;
        btgt0 = 32'h0; jidx0 = 26'h0;
        rst_n1 = 1'b0; stall1 = 0; flush1 = 0; br1 = 0; jump1 = 0;
        btgt1 = 32'h0; jidx1 = 26'h0;

        // reset state, held across a clock edge
        @(posedge clk); #1;
        chk_all0("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        chk("reset.addr1", addr1, 32'hFFFF_FFFC);

        @(negedge clk);
        rst_n0 = 1'b1;

        // table-driven portion
        for (int i = 0; i < NV; i++) begin
            stall0 = vecs[i].stall; flush0 = vecs[i].flush; br0 = vecs[i].br;
            btgt0  = vecs[i].btgt;  jump0  = vecs[i].jump;  jidx0 = vecs[i].jidx;
            @(posedge clk); #1;
            chk_all0($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_inst,
                     vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_cnt);
            @(negedge clk);
        end
        stall0 = 0; flush0 = 0; br0 = 0; jump0 = 0; btgt0 = 32'h0; jidx0 = 26'h0;

        // asynchronous reset mid-cycle at Addr 0x20
        br0 = 1'b1; btgt0 = 32'h0000_001C;
        @(posedge clk); #1;
        chk_all0("br1c", 32'h0000_001C, 32'h0, 32'h0, 1'b0, 16'd8);
        @(negedge clk);
        br0 = 1'b0; btgt0 = 32'h0;
        @(posedge clk); #1;
        chk_all0("ld20", 32'h0000_0020, 32'hA5A5_001C, 32'h0000_0020, 1'b1, 16'd9);
        #1 rst_n0 = 1'b0;
        #1;
        chk_all0("arst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n0 = 1'b1;
        @(posedge clk); #1;
        chk_all0("post_rst", 32'h0000_0004, 32'h0, 32'h0000_0004, 1'b1, 16'd1);

        // PC wrap on dut1
        @(negedge clk);
        rst_n1 = 1'b1;
        @(posedge clk); #1;
        chk("wrap.addr",  addr1,              32'h0);
        chk("wrap.pc4",   ifid_pc41,          32'h0);
        chk("wrap.inst",  ifid_inst1,         32'h5A5A_FFFC);
        chk("wrap.valid", {31'd0, valid1},    32'd1);
        chk("wrap.count", {16'd0, cnt1},      32'd1);
        $display("wrap addr=%h pc4=%h inst=%h count=%0d", addr1, ifid_pc41, ifid_inst1, cnt1);

        // free-running loads bring Fetch_Count to 16'hFFFF, then one more wraps it
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt.ffff", {16'd0, cnt1}, 32'h0000_FFFF);
        $display("cnt_pre count=%h", cnt1);
        @(posedge clk); #1;
        chk("cnt.wrap", {16'd0, cnt1}, 32'h0);
        $display("cnt_wrap count=%h", cnt1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
